fetch_controller: RTL and testbench

- Sequences the instruction memory: owns the fetch PC, issues word requests and buffers returned instructions in a small FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Accepts redirects (branch/jump) from execute and a halt request from the control unit.
- Sits between the instruction memory and the decode stage of the SEQ/pipelined core.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_controller.sv | 116 +++++++++++
 tb/tb_fetch_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Entries carry the fetched instruction together with the PC it came from.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_000D;
    localparam int          ENTRY_W   = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// A flush empties the queue and wins over a push or pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_data,
    output logic [CW-1:0]      count,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, issues one-word memory
// requests under credit control and hands buffered instructions to decode.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC,
    parameter int          FQ_DEPTH  = 2,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        misaligned_err,
    output logic [1:0]  fsm_state
);

    import fetch_pkg::state_t;
    import fetch_pkg::IDLE;
    import fetch_pkg::FETCH;
    import fetch_pkg::HALTED;
    import fetch_pkg::entry_t;

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    entry_t        head;
    entry_t        push_entry;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          pop_req;
    logic          q_pop;
    logic          q_push;
    logic          resp_kill;
    logic [CW:0]   occupancy;
    logic [CW:0]   limit;

    // Decode handshake: an entry transfers on a cycle where id_valid and
    // id_ready are both high; id_* hold steady while id_ready is low.
    assign pop_req = id_valid & id_ready;

    // A redirect voids any pop and kills the response landing this cycle.
    assign resp_kill  = inflight & redirect_valid;
    assign q_pop      = pop_req & ~redirect_valid;
    assign q_push     = inflight & ~resp_kill;
    assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

    // Credit check: queued + outstanding, less the entry leaving now.
    assign occupancy = (CW+1)'(q_count) + (CW+1)'(inflight);
    assign limit     = (CW+1)'(FQ_DEPTH) + (CW+1)'(pop_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (halt)  state_nxt = HALTED;
            HALTED:  if (!halt) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == FETCH) && !halt && !redirect_valid && (occupancy < limit);
        imem_addr = pc;
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= RESET_PC;
            misaligned_err <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) inflight_pc <= pc;
            if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
            else if (imem_req)   pc <= pc + 32'd4;
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) misaligned_err <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head_data (head),
        .count     (q_count),
        .empty     (q_empty)
    );

    assign id_valid = ~q_empty;
    assign id_instr = q_empty ? NOP_INSTR : head.instr;
    assign id_pc    = q_empty ? 32'd0     : head.pc;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: behavioural instruction memory,
// cycle-by-cycle expected outputs and a final summary.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        misaligned_err;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [64];

    fetch_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .misaligned_err (misaligned_err),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    // Word i holds 0xA000_0000 + i; data is valid the cycle after a request.
    initial for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    always @(posedge clk) imem_rdata <= imem_req ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] instr, input logic [31:0] pc);
        chk({tag, ".req"}, 32'(imem_req), 32'(req));
        if (req) chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".valid"}, 32'(id_valid), 32'(v));
        if (v) begin
            chk({tag, ".instr"}, id_instr, instr);
            chk({tag, ".pc"}, id_pc, pc);
        end
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, ".req"},   32'(imem_req), 32'd0);
        chk({tag, ".valid"}, 32'(id_valid), 32'd0);
        chk({tag, ".instr"}, id_instr, 32'h0000_000D);
        chk({tag, ".pc"},    id_pc, 32'd0);
        chk({tag, ".addr"},  imem_addr, 32'd0);
        chk({tag, ".err"},   32'(misaligned_err), 32'd0);
        chk({tag, ".state"}, 32'(fsm_state), 32'd0);
    endtask

    task automatic cyc(input logic rdy, input logic hlt, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        id_ready       = rdy;
        halt           = hlt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic pulse_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Sequential fetch with decode always ready
        pulse_reset();
        expect_reset("rst0");
        release_reset();
        expect_reset("seq.c0");
        cyc(1, 0, 0, 0); expect_cyc("seq.c1", 1, 32'h0, 0, 0, 0);
        chk("seq.c1.state", 32'(fsm_state), 32'd1);
        cyc(1, 0, 0, 0); expect_cyc("seq.c2", 1, 32'h4, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("seq.c3", 1, 32'h8, 1, 32'hA000_0000, 32'h0);
        cyc(1, 0, 0, 0); expect_cyc("seq.c4", 1, 32'hC, 1, 32'hA000_0001, 32'h4);
        cyc(1, 0, 0, 0); expect_cyc("seq.c5", 1, 32'h10, 1, 32'hA000_0002, 32'h8);
        cyc(1, 0, 0, 0); expect_cyc("seq.c6", 1, 32'h14, 1, 32'hA000_0003, 32'hC);

        // Backpressure: decode stalls for 6 cycles starting at first valid
        @(negedge clk); pulse_reset(); release_reset();
        cyc(0, 0, 0, 0); expect_cyc("bp.c1", 1, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0); expect_cyc("bp.c2", 1, 32'h4, 0, 0, 0);
        for (int i = 3; i <= 8; i++) begin
            cyc(0, 0, 0, 0);
            expect_cyc($sformatf("bp.c%0d", i), 0, 0, 1, 32'hA000_0000, 32'h0);
        end
        cyc(1, 0, 0, 0); expect_cyc("bp.c9",  1, 32'h8, 1, 32'hA000_0000, 32'h0);
        cyc(1, 0, 0, 0); expect_cyc("bp.c10", 1, 32'hC, 1, 32'hA000_0001, 32'h4);
        cyc(1, 0, 0, 0); expect_cyc("bp.c11", 1, 32'h10, 1, 32'hA000_0002, 32'h8);

        // Redirect to 0x40 while the request for 0x8 is outstanding
        @(negedge clk); pulse_reset(); release_reset();
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("rd.c3", 1, 32'h8, 1, 32'hA000_0000, 32'h0);
        cyc(1, 0, 1, 32'h40); expect_cyc("rd.c4", 0, 0, 1, 32'hA000_0001, 32'h4);
        cyc(1, 0, 0, 0); expect_cyc("rd.c5", 1, 32'h40, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("rd.c6", 1, 32'h44, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("rd.c7", 1, 32'h48, 1, 32'hA000_0010, 32'h40);
        cyc(1, 0, 0, 0); expect_cyc("rd.c8", 1, 32'h4C, 1, 32'hA000_0011, 32'h44);

        // Halt for 5 cycles with two entries queued
        @(negedge clk); pulse_reset(); release_reset();
        cyc(0, 0, 0, 0); expect_cyc("hl.c1", 1, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0); expect_cyc("hl.c2", 1, 32'h4, 0, 0, 0);
        cyc(0, 0, 0, 0); expect_cyc("hl.c3", 0, 0, 1, 32'hA000_0000, 32'h0);
        cyc(1, 1, 0, 0); expect_cyc("hl.c4", 0, 0, 1, 32'hA000_0000, 32'h0);
        cyc(1, 1, 0, 0); expect_cyc("hl.c5", 0, 0, 1, 32'hA000_0001, 32'h4);
        chk("hl.c5.state", 32'(fsm_state), 32'd2);
        for (int i = 6; i <= 8; i++) begin
            cyc(1, 1, 0, 0);
            expect_cyc($sformatf("hl.c%0d", i), 0, 0, 0, 0, 0);
        end
        cyc(1, 0, 0, 0); expect_cyc("hl.c9", 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("hl.c10", 1, 32'h8, 0, 0, 0);
        chk("hl.c10.state", 32'(fsm_state), 32'd1);
        cyc(1, 0, 0, 0); expect_cyc("hl.c11", 1, 32'hC, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("hl.c12", 1, 32'h10, 1, 32'hA000_0002, 32'h8);

        // Misaligned redirect to 0x42 follows on from the halt sequence
        cyc(1, 0, 1, 32'h42); expect_cyc("ma.c13", 0, 0, 1, 32'hA000_0003, 32'hC);
        chk("ma.c13.err", 32'(misaligned_err), 32'd0);
        cyc(1, 0, 0, 0); expect_cyc("ma.c14", 1, 32'h40, 0, 0, 0);
        chk("ma.c14.err", 32'(misaligned_err), 32'd1);
        cyc(1, 0, 0, 0); expect_cyc("ma.c15", 1, 32'h44, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("ma.c16", 1, 32'h48, 1, 32'hA000_0010, 32'h40);
        chk("ma.c16.err", 32'(misaligned_err), 32'd1);
        cyc(1, 0, 0, 0); expect_cyc("ma.c17", 1, 32'h4C, 1, 32'hA000_0011, 32'h44);
        chk("ma.c17.err", 32'(misaligned_err), 32'd1);
        @(negedge clk); pulse_reset();
        chk("ma.rst.err", 32'(misaligned_err), 32'd0);
        release_reset();
        chk("ma.rel.err", 32'(misaligned_err), 32'd0);

        // Asynchronous reset with a request outstanding
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("ar.c4", 1, 32'hC, 1, 32'hA000_0001, 32'h4);
        #1;
        pulse_reset();
        expect_reset("ar.rst");
        release_reset();
        expect_reset("ar.c0");
        cyc(1, 0, 0, 0); expect_cyc("ar.c1", 1, 32'h0, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("ar.c2", 1, 32'h4, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_cyc("ar.c3", 1, 32'h8, 1, 32'hA000_0000, 32'h0);
        cyc(1, 0, 0, 0); expect_cyc("ar.c4b", 1, 32'hC, 1, 32'hA000_0001, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
